// File: rtl/sim_data_gen_ctrl.sv
// Burst scheduler for the simulated counting data generator on the DDR FIFO write path.
// Bursts of BurstLen enable cycles are separated by idle gaps, gated on FIFO room, repeated BurstCount times or continuously.
module sim_data_gen_ctrl #(
    parameter int CNT_W = 16,
    parameter int WC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Stop,
    input  logic [CNT_W-1:0] BurstLen,
    input  logic [CNT_W-1:0] GapLen,
    input  logic [CNT_W-1:0] BurstCount,
    input  logic             FifoAlmostFull,
    output logic             GenEn,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] BurstIdx,
    output logic [WC_W-1:0]  WordCount
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ROOM,
        BURST,
        GAP
    } state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] lenQ, lenNext;
    logic [CNT_W-1:0] gapQ, gapNext;
    logic [CNT_W-1:0] countQ, countNext;
    logic [CNT_W-1:0] phaseCnt, phaseNext;
    logic             stopPending, pendNext;
    logic             genEnNext, busyNext, doneNext;
    logic [CNT_W-1:0] idxNext;
    logic [WC_W-1:0]  wcNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lenQ        <= '0;
            gapQ        <= '0;
            countQ      <= '0;
            phaseCnt    <= '0;
            stopPending <= 1'b0;
            GenEn       <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            BurstIdx    <= '0;
            WordCount   <= '0;
        end else begin
            state       <= stateNext;
            lenQ        <= lenNext;
            gapQ        <= gapNext;
            countQ      <= countNext;
            phaseCnt    <= phaseNext;
            stopPending <= pendNext;
            GenEn       <= genEnNext;
            Busy        <= busyNext;
            Done        <= doneNext;
            BurstIdx    <= idxNext;
            WordCount   <= wcNext;
        end
    end

    // phaseCnt numbers the current burst or gap cycle starting at 1, so it
    // equals the latched length on the last cycle of that phase.
    always_comb begin
        stateNext = state;
        lenNext   = lenQ;
        gapNext   = gapQ;
        countNext = countQ;
        phaseNext = phaseCnt;
        pendNext  = stopPending;
        genEnNext = 1'b0;
        doneNext  = 1'b0;
        idxNext   = BurstIdx;
        wcNext    = WordCount + WC_W'(GenEn);

        case (state)
            IDLE: begin
                if (Start && !Stop && (BurstLen != '0)) begin
                    lenNext   = BurstLen;
                    gapNext   = (GapLen == '0) ? CNT_W'(1) : GapLen;
                    countNext = BurstCount;
                    idxNext   = '0;
                    wcNext    = '0;
                    pendNext  = 1'b0;
                    stateNext = WAIT_ROOM;
                end
            end
            WAIT_ROOM: begin
                if (Stop) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end else if (!FifoAlmostFull) begin
                    genEnNext = 1'b1;
                    phaseNext = CNT_W'(1);
                    stateNext = BURST;
                end
            end
            BURST: begin
                // Never paused: dropping enable would restart the generator's count.
                if (Stop) begin
                    pendNext = 1'b1;
                end
                if (phaseCnt == lenQ) begin
                    idxNext   = BurstIdx + CNT_W'(1);
                    phaseNext = CNT_W'(1);
                    stateNext = GAP;
                end else begin
                    genEnNext = 1'b1;
                    phaseNext = phaseCnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (Stop) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end else if (phaseCnt == gapQ) begin
                    if (stopPending || ((countQ != '0) && (BurstIdx == countQ))) begin
                        doneNext  = 1'b1;
                        stateNext = IDLE;
                    end else if (!FifoAlmostFull) begin
                        // Room check folded into the gap end so the low time is exactly the gap length.
                        genEnNext = 1'b1;
                        phaseNext = CNT_W'(1);
                        stateNext = BURST;
                    end else begin
                        stateNext = WAIT_ROOM;
                    end
                end else begin
                    phaseNext = phaseCnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

endmodule

// File: doc/sim_data_gen_ctrl.md
Name: sim_data_gen_ctrl

Overview:
- Burst scheduler for the simulated 32-bit counting data generator that feeds the DDR FIFO write path.
- Drives the generator's enable as bursts of BurstLen cycles separated by idle gaps, repeated BurstCount times or continuously.
- Holds off each burst start until the downstream FIFO reports room.
- Reports progress (burst index, word count) and a completion pulse for bench and debug control.

Parameters:
- CNT_W, 16, width of BurstLen/GapLen/BurstCount/BurstIdx
- WC_W, 32, width of WordCount

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- Start  in  1  single-cycle request; latches config and begins a run (accepted only in IDLE)
- Stop  in  1  single-cycle request; graceful end of the run
- BurstLen  in  CNT_W  enable cycles per burst (0 = Start rejected)
- GapLen  in  CNT_W  low cycles between bursts (0 treated as 1)
- BurstCount  in  CNT_W  bursts per run (0 = continuous until Stop)
- FifoAlmostFull  in  1  downstream FIFO has less than one burst of headroom
- GenEn  out  1  registered enable to the data generator
- Busy  out  1  high in any state except IDLE
- Done  out  1  one-cycle pulse when a run ends
- BurstIdx  out  CNT_W  number of completed bursts in the current run
- WordCount  out  WC_W  number of GenEn-high cycles in the current run (wraps)

Behaviour:
- Reset: state IDLE; GenEn=0, Busy=0, Done=0, BurstIdx=0, WordCount=0; pending-stop flag cleared. Reset mid-burst drops GenEn on the next edge.
- All outputs are registered.
- States: IDLE, WAIT_ROOM, BURST, GAP.
- IDLE:
  - Start=1 with BurstLen!=0 and Stop=0: latch BurstLen/GapLen/BurstCount, clear BurstIdx and WordCount, go to WAIT_ROOM.
  - Start with BurstLen=0, or Start and Stop in the same cycle: ignored.
- WAIT_ROOM:
  - FifoAlmostFull=0: go to BURST with GenEn=1 from the same edge.
  - Start-sample edge to first GenEn-high cycle is 2 cycles minimum.
  - Stop sampled here: go to IDLE with Done pulse.
- BURST:
  - GenEn stays high for exactly latched BurstLen cycles; WordCount increments each of those cycles.
  - FifoAlmostFull is ignored mid-burst; bursts are never paused, because dropping enable restarts the generator count. FIFO threshold must give at least BurstLen+2 words of headroom.
  - Stop during BURST sets a pending flag; the burst completes.
  - After the last cycle: GenEn=0, BurstIdx+1, go to GAP.
- GAP:
  - GenEn low for max(GapLen,1) cycles. At least 1 cycle is required so the generator's counter returns to 0.
  - At gap end: if pending stop, or (BurstCount!=0 and BurstIdx==BurstCount), go to IDLE with Done=1 for one cycle. Otherwise go to WAIT_ROOM.
  - Stop sampled in GAP: end immediately (IDLE + Done), no further bursts.
- Start while Busy: ignored. Config input changes while Busy: no effect until the next Start.
- Downstream view: each burst yields exactly BurstLen valid words 0..BurstLen-1, with DataOutValid lagging GenEn by 1 cycle.
- Counter behaviour: WordCount wraps modulo 2^WC_W. BurstIdx wraps in continuous mode. In continuous mode the run ends only via Stop.

Test Plan:
- BurstLen=4, GapLen=2, BurstCount=3, AF=0, Start -> GenEn high 4 cycles, low 2, three times; generator emits 0..3 each burst; Done pulses once after last gap; BurstIdx=3, WordCount=12, Busy falls with Done.
- AF=1 at Start, released after 10 cycles -> GenEn stays 0 for those 10 cycles, then BurstLen=8 burst starts; AF raised mid-burst -> burst still completes 8 cycles; next burst waits for AF=0.
- BurstCount=0, BurstLen=16, Stop pulsed mid second burst -> second burst completes all 16 cycles, gap runs, then Done; BurstIdx=2, WordCount=32.
- GapLen=0, BurstLen=1, BurstCount=2 -> GenEn pattern 1,0,1,0; generator output 0 both times; Done after second gap.
- Start with BurstLen=0 -> stays IDLE, Busy=0, no Done; second Start while Busy -> ignored, latched config unchanged.
- rst asserted during BURST at cycle 3 of 8 -> next edge GenEn=0, IDLE, counters 0; new Start runs normally from WordCount=0.
